// File: rtl/mips_pipe_pkg.sv
// Shared types for the 5-stage MIPS pipeline: widths, ALU opcodes, ID/EX control bundle.
// The control bundle zeroes to a harmless NOP, so a bubble is just CTRL_NOP.
package mips_pipe_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W   = 4;
  localparam int CNT_W      = 16;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic                alu_src;
    logic                reg_dst;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic                mem_to_reg;
    logic [ALU_OP_W-1:0] alu_op;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard: a valid load in EX whose non-$zero rt is read by
// the live (valid, unflushed) instruction in ID. No state, zero latency.
module load_use_detect #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      ex_valid_i,
  input  logic                      ex_mem_read_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rt_addr_i,
  input  logic                      id_valid_i,
  input  logic                      id_flush_i,
  input  logic                      id_uses_rs_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr_i,
  input  logic                      id_uses_rt_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr_i,
  output logic                      hz_o
);

  logic ex_is_load;
  logic id_live;
  logic rs_match;
  logic rt_match;

  assign ex_is_load = ex_valid_i & ex_mem_read_i & (ex_rt_addr_i != '0);
  assign id_live    = id_valid_i & ~id_flush_i;
  assign rs_match   = id_uses_rs_i & (id_rs_addr_i == ex_rt_addr_i);
  assign rt_match   = id_uses_rt_i & (id_rt_addr_i == ex_rt_addr_i);
  assign hz_o       = ex_is_load & id_live & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use detection: 1-cycle latency, holds on stall__i,
// bubbles on flush or hazard and requests an upstream hold via load_use_stall__o.
module id_ex_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W,
  parameter int REG_ADDR_WIDTH = REG_ADDR_W,
  parameter int ALU_OP_WIDTH   = ALU_OP_W,
  parameter int CNT_WIDTH      = CNT_W
) (
  input  logic                      clock__i,
  input  logic                      reset_n__i,
  input  logic                      valid__i,
  input  logic                      stall__i,
  input  logic                      flush__i,
  input  logic [DATA_WIDTH-1:0]     pc_plus4__i,
  input  logic [DATA_WIDTH-1:0]     rs_data__i,
  input  logic [DATA_WIDTH-1:0]     rt_data__i,
  input  logic [DATA_WIDTH-1:0]     imm__i,
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr__i,
  input  logic [REG_ADDR_WIDTH-1:0] rt_addr__i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr__i,
  input  logic                      uses_rs__i,
  input  logic                      uses_rt__i,
  input  logic                      alu_src__i,
  input  logic                      reg_dst__i,
  input  logic                      mem_read__i,
  input  logic                      mem_write__i,
  input  logic                      reg_write__i,
  input  logic                      mem_to_reg__i,
  input  logic [ALU_OP_WIDTH-1:0]   alu_op__i,
  output logic [DATA_WIDTH-1:0]     pc_plus4__o,
  output logic [DATA_WIDTH-1:0]     rs_data__o,
  output logic [DATA_WIDTH-1:0]     rt_data__o,
  output logic [DATA_WIDTH-1:0]     imm__o,
  output logic [REG_ADDR_WIDTH-1:0] rs_addr__o,
  output logic [REG_ADDR_WIDTH-1:0] rt_addr__o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr__o,
  output logic                      alu_src__o,
  output logic                      reg_dst__o,
  output logic                      mem_read__o,
  output logic                      mem_write__o,
  output logic                      reg_write__o,
  output logic                      mem_to_reg__o,
  output logic [ALU_OP_WIDTH-1:0]   alu_op__o,
  output logic                      valid__o,
  output logic                      load_use_stall__o,
  output logic [CNT_WIDTH-1:0]      bubble_count__o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     pc_plus4;
    logic [DATA_WIDTH-1:0]     rs_data;
    logic [DATA_WIDTH-1:0]     rt_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs_addr;
    logic [REG_ADDR_WIDTH-1:0] rt_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
  } id_ex_dp_t;

  id_ex_dp_t             dp_in, dp_d, dp_q;
  id_ex_ctrl_t           ctrl_in, ctrl_d, ctrl_q;
  logic                  valid_d, valid_q;
  logic [CNT_WIDTH-1:0]  cnt_d, cnt_q;
  logic                  hz;

  always_comb begin
    dp_in          = '0;
    dp_in.pc_plus4 = pc_plus4__i;
    dp_in.rs_data  = rs_data__i;
    dp_in.rt_data  = rt_data__i;
    dp_in.imm      = imm__i;
    dp_in.rs_addr  = rs_addr__i;
    dp_in.rt_addr  = rt_addr__i;
    dp_in.rd_addr  = rd_addr__i;
  end

  // An invalid slot still carries its datapath, but never its side-effecting controls.
  always_comb begin
    ctrl_in = CTRL_NOP;
    if (valid__i) begin
      ctrl_in.alu_src    = alu_src__i;
      ctrl_in.reg_dst    = reg_dst__i;
      ctrl_in.mem_read   = mem_read__i;
      ctrl_in.mem_write  = mem_write__i;
      ctrl_in.reg_write  = reg_write__i;
      ctrl_in.mem_to_reg = mem_to_reg__i;
      ctrl_in.alu_op     = ALU_OP_W'(alu_op__i);
    end
  end

  load_use_detect #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_load_use_detect (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rt_addr_i  (dp_q.rt_addr),
    .id_valid_i    (valid__i),
    .id_flush_i    (flush__i),
    .id_uses_rs_i  (uses_rs__i),
    .id_rs_addr_i  (rs_addr__i),
    .id_uses_rt_i  (uses_rt__i),
    .id_rt_addr_i  (rt_addr__i),
    .hz_o          (hz)
  );

  // A frozen pipe cannot retire the load, so the upstream hold is only meaningful when not stalled.
  assign load_use_stall__o = hz & ~stall__i;

  always_comb begin
    dp_d    = dp_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (stall__i) begin
      dp_d    = dp_q;
    end else if (flush__i || hz) begin
      dp_d    = '0;
      ctrl_d  = CTRL_NOP;
      valid_d = 1'b0;
      if (hz && (cnt_q != {CNT_WIDTH{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      dp_d    = dp_in;
      ctrl_d  = ctrl_in;
      valid_d = valid__i;
    end
  end

  always_ff @(posedge clock__i or negedge reset_n__i) begin
    if (!reset_n__i) begin
      dp_q    <= '0;
      ctrl_q  <= CTRL_NOP;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      dp_q    <= dp_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_plus4__o     = dp_q.pc_plus4;
  assign rs_data__o      = dp_q.rs_data;
  assign rt_data__o      = dp_q.rt_data;
  assign imm__o          = dp_q.imm;
  assign rs_addr__o      = dp_q.rs_addr;
  assign rt_addr__o      = dp_q.rt_addr;
  assign rd_addr__o      = dp_q.rd_addr;
  assign alu_src__o      = ctrl_q.alu_src;
  assign reg_dst__o      = ctrl_q.reg_dst;
  assign mem_read__o     = ctrl_q.mem_read;
  assign mem_write__o    = ctrl_q.mem_write;
  assign reg_write__o    = ctrl_q.reg_write;
  assign mem_to_reg__o   = ctrl_q.mem_to_reg;
  assign alu_op__o       = ALU_OP_WIDTH'(ctrl_q.alu_op);
  assign valid__o        = valid_q;
  assign bubble_count__o = cnt_q;

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, with integrated load-use hazard detection.
- Captures decoded operands, immediate, register addresses and control from ID.
- Presents them to EX. alu_src__o and reg_dst__o drive the select inputs of the EX-stage 2:1 operand and destination muxes.
- Requests an upstream (PC, IF/ID) hold and inserts a bubble on a load-use hazard.

Parameters:
- DATA_WIDTH, 32, width of PC/operand/immediate fields.
- REG_ADDR_WIDTH, 5, register-file address width.
- ALU_OP_WIDTH, 4, ALU operation code width.
- CNT_WIDTH, 16, bubble performance counter width.

Ports:
- clock__i  in  1  rising-edge clock.
- reset_n__i  in  1  reset, asynchronous, active-low.
- valid__i  in  1  ID holds a real instruction.
- stall__i  in  1  global freeze from downstream (MEM wait).
- flush__i  in  1  squash the ID instruction (taken branch/jump).
- pc_plus4__i / rs_data__i / rt_data__i / imm__i  in  DATA_WIDTH  ID datapath fields.
- rs_addr__i / rt_addr__i / rd_addr__i  in  REG_ADDR_WIDTH  register addresses.
- uses_rs__i / uses_rt__i  in  1  ID instruction reads rs/rt.
- alu_src__i / reg_dst__i / mem_read__i / mem_write__i / reg_write__i / mem_to_reg__i  in  1  control.
- alu_op__i  in  ALU_OP_WIDTH  ALU operation.
- All of the above datapath, address and control fields  out  same widths  registered copies, suffix __o.
- valid__o  out  1  EX holds a real instruction.
- load_use_stall__o  out  1  combinational; hold PC and IF/ID this cycle.
- bubble_count__o  out  CNT_WIDTH  count of load-use bubbles inserted.

Behaviour:
- Reset (async assert, sync-free deassert): every registered output = 0, including valid__o; bubble_count__o = 0.
- Hazard (combinational):
  - hz = valid__o & mem_read__o & (rt_addr__o != 0) & valid__i & ~flush__i & ((uses_rs__i & rs_addr__i == rt_addr__o) | (uses_rt__i & rt_addr__i == rt_addr__o)).
  - load_use_stall__o = hz & ~stall__i.
- Per clock edge, priority order:
  1. stall__i = 1: hold all registers. Counter holds. flush__i is ignored; the upstream controller holds flush until the stall releases.
  2. flush__i = 1: bubble.
  3. hz = 1: bubble; counter += 1, saturating at all-ones.
  4. Otherwise: load all fields; valid__o <= valid__i.
- Bubble:
  - valid__o = 0; reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst = 0; alu_op = 0.
  - All datapath and address fields = 0 (deterministic for checking).
- valid__i = 0 with a normal load: control outputs are still forced to 0 (no architectural side effects from an invalid slot).
- Latency: 1 cycle ID→EX. A load-use stall costs exactly one bubble; the dependent instruction enters EX two cycles after the load did.
- Back-to-back loads with chained dependency: each hazard yields exactly one bubble.
- The $zero destination never triggers a hazard.

Decomposition:
- Shared package mips_pipe_pkg:
  - id_ex_ctrl_t packed struct (alu_src, reg_dst, mem_read, mem_write, reg_write, mem_to_reg, alu_op).
  - ALU op enum.
  - Width localparams.
  - Bubble constant CTRL_NOP.
- One sub-module: load_use_detect, the combinational hz equation. It is reused by the forwarding/hazard bench.

Test Plan:
- Reset mid-operation: valid__o=1, reg_write__o=1, assert reset_n__i=0 asynchronously → all outputs 0 before the next edge; bubble_count__o=0.
- Normal flow: rs_data__i=0x1234, imm__i=0xFFFF_FFF0, alu_src__i=1, valid__i=1 → next cycle rs_data__o=0x1234, imm__o=0xFFFF_FFF0, alu_src__o=1, valid__o=1.
- Load-use: EX holds lw with rt_addr__o=5; ID has add with uses_rs__i=1, rs_addr__i=5 → load_use_stall__o=1 that cycle; next cycle valid__o=0, controls 0, bubble_count__o=1; following cycle the add is loaded.
- Zero-register/no-use: EX lw with rt_addr__o=0, or uses_rt__i=0 with rt_addr__i=5 → load_use_stall__o=0, no bubble.
- Stall priority: stall__i=1 with flush__i=1 and a hazard present → all outputs unchanged, load_use_stall__o=0, counter unchanged; stall__i drops with flush__i=1 → bubble, counter unchanged.
- Counter saturation: CNT_WIDTH=4, force 17 hazards → bubble_count__o stops at 15.
